// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcode map, PC step and the fetch-stage state encoding.
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] HALT_OP   = 4'hF;

  localparam int PC_INC = 2;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_register.sv
// Generic PC holding register: async-reset flops with a write enable.
module pc_register #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] d_i,
  output logic [ADDR_W-1:0] q_o
);

  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pc_q <= RESET_PC;
    else if (we_i) pc_q <= d_i;
  end

  assign q_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// WISC instruction fetch: registered PC, single outstanding imem request,
// valid/ready hand-off to decode, redirect with squash, and HLT detection.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                OP_W     = 4,
  parameter int                PC_INC   = wisc_pkg::PC_INC,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [OP_W-1:0]   HALT_OP  = wisc_pkg::HALT_OP
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  instr_pc_next,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               hlt,
  output logic [ADDR_W-1:0]  pc
);

  import wisc_pkg::*;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

  fetch_state_e       state_q, state_d;
  logic               run_q;
  logic               squash_q, squash_d;
  logic               halt_pend_q, halt_pend_d;
  logic               instr_valid_q, instr_valid_d;
  logic               hlt_q, hlt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0]  instr_pc_next_q, instr_pc_next_d;
  logic [ADDR_W-1:0]  sq_addr_q, sq_addr_d;
  logic               pc_we;
  logic [ADDR_W-1:0]  pc_d, pc_q;
  logic [OP_W-1:0]    rsp_op;

  assign rsp_op = imem_rsp_data[INSTR_W-1 -: OP_W];

  pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk  (clk),
    .rst  (rst),
    .we_i (pc_we),
    .d_i  (pc_d),
    .q_o  (pc_q)
  );

  always_comb begin
    state_d         = state_q;
    squash_d        = squash_q;
    halt_pend_d     = halt_pend_q;
    instr_valid_d   = instr_valid_q;
    hlt_d           = hlt_q;
    instr_d         = instr_q;
    instr_pc_d      = instr_pc_q;
    instr_pc_next_d = instr_pc_next_q;
    sq_addr_d       = sq_addr_q;
    pc_we           = 1'b0;
    pc_d            = pc_q;
    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          pc_we       = 1'b1;
          pc_d        = redirect_pc;
          halt_pend_d = 1'b0;
          // A request still in flight must finish on its old address before the new pc goes out.
          squash_d    = run_q && !imem_rsp_valid;
          if (!squash_q) sq_addr_d = pc_q;
        end else if (run_q && imem_rsp_valid) begin
          if (squash_q) begin
            squash_d = 1'b0;
          end else begin
            instr_d         = imem_rsp_data;
            instr_pc_d      = pc_q;
            instr_pc_next_d = pc_q + PC_STEP;
            instr_valid_d   = 1'b1;
            state_d         = HOLD;
            if (rsp_op == HALT_OP) begin
              halt_pend_d = 1'b1;
            end else begin
              pc_we = 1'b1;
              pc_d  = pc_q + PC_STEP;
            end
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_we         = 1'b1;
          pc_d          = redirect_pc;
          instr_valid_d = 1'b0;
          halt_pend_d   = 1'b0;
          state_d       = FETCH;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          if (halt_pend_q) begin
            state_d = HALTED;
            hlt_d   = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
      HALTED: ;
      default: state_d = FETCH;
    endcase
  end

  // run_q holds off the first request until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= FETCH;
      run_q           <= 1'b0;
      squash_q        <= 1'b0;
      halt_pend_q     <= 1'b0;
      instr_valid_q   <= 1'b0;
      hlt_q           <= 1'b0;
      instr_q         <= '0;
      instr_pc_q      <= '0;
      instr_pc_next_q <= '0;
      sq_addr_q       <= '0;
    end else begin
      state_q         <= state_d;
      run_q           <= 1'b1;
      squash_q        <= squash_d;
      halt_pend_q     <= halt_pend_d;
      instr_valid_q   <= instr_valid_d;
      hlt_q           <= hlt_d;
      instr_q         <= instr_d;
      instr_pc_q      <= instr_pc_d;
      instr_pc_next_q <= instr_pc_next_d;
      sq_addr_q       <= sq_addr_d;
    end
  end

  assign imem_req      = run_q && (state_q == FETCH);
  assign imem_addr     = squash_q ? sq_addr_q : pc_q;
  assign pc            = pc_q;
  assign instr_valid   = instr_valid_q;
  assign instr         = instr_q;
  assign instr_pc      = instr_pc_q;
  assign instr_pc_next = instr_pc_next_q;
  assign hlt           = hlt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency memory responder, scoreboard of the
// architectural fetch stream, directed scenarios followed by random traffic.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] instr_pc_next;
  logic        instr_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        hlt;
  logic [15:0] pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .OP_W     (4),
    .PC_INC   (2),
    .RESET_PC (16'h0000),
    .HALT_OP  (4'hF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_next  (instr_pc_next),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .hlt            (hlt),
    .pc             (pc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Memory contents: addresses 0..6 hold 1000,2000,3000,4000; hlt_addr holds HLT.
  logic [15:0] hlt_addr;
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    if (a == hlt_addr) return 16'hF000;
    if (a < 16'h0008) return 16'(((a >> 1) + 16'd1) << 12);
    w = 16'(a * 16'h9E37) ^ 16'h5A5A;
    if (w[15:12] == 4'hF) w[15:12] = 4'h3;
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory responder: one outstanding request, response mem_lat cycles after acceptance.
  int          mem_lat;
  bit          mem_busy;
  int          mem_cnt;
  logic [15:0] mem_addr_cap;
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 16'h0;
    mem_busy       = 1'b0;
    mem_cnt        = 0;
    mem_addr_cap   = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mem_busy       = 1'b0;
        imem_rsp_valid = 1'b0;
      end else begin
        if (imem_rsp_valid) begin
          imem_rsp_valid = 1'b0;
          mem_busy       = 1'b0;
        end
        imem_rsp_data = 16'($urandom);
        if (!mem_busy && imem_req) begin
          mem_busy     = 1'b1;
          mem_addr_cap = imem_addr;
          mem_cnt      = mem_lat;
        end else if (mem_busy) begin
          mem_cnt--;
          if (mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr_cap);
          end
        end
      end
    end
  end

  // Scoreboard: exp_q holds the pc of the next instruction decode should accept.
  logic [15:0] exp_q[$];
  bit          model_halted;
  logic [15:0] halt_pc;
  bit          chk_spacing;
  int          cyc;
  int          last_acc;
  int          idle;
  bit          prev_hold;
  logic [15:0] prev_instr;
  logic [15:0] prev_pc;

  initial begin
    logic [15:0] e;
    logic [15:0] w;
    logic [15:0] en;
    model_halted = 1'b0;
    halt_pc      = 16'h0;
    cyc          = 0;
    last_acc     = -1;
    idle         = 0;
    prev_hold    = 1'b0;
    prev_instr   = 16'h0;
    prev_pc      = 16'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        exp_q.push_back(16'h0000);
        model_halted = 1'b0;
        prev_hold    = 1'b0;
        last_acc     = -1;
        idle         = 0;
        continue;
      end
      check("hlt_flag", 32'(hlt), 32'(model_halted));
      if (model_halted) begin
        check("halted_idle", 32'({imem_req, instr_valid}), 32'd0);
        check("halted_pc", 32'(pc), 32'(halt_pc));
      end
      if (mem_busy)
        check("req_addr_hold", 32'({imem_req, imem_addr}), 32'({1'b1, mem_addr_cap}));
      if (prev_hold)
        check("hold_stable", 32'({instr_valid, instr_pc}) ^ 32'({prev_instr, 16'h0}),
              32'({1'b1, prev_pc}) ^ 32'({instr, 16'h0}));
      if (instr_valid) check("req_low_in_hold", 32'(imem_req), 32'd0);
      prev_hold  = instr_valid && !instr_ready && !redirect_valid;
      prev_instr = instr;
      prev_pc    = instr_pc;

      if (instr_valid && instr_ready && !redirect_valid) begin
        idle = 0;
        if (model_halted || exp_q.size() == 0) begin
          check("accept_when_halted", 32'(instr_valid), 32'd0);
        end else begin
          e  = exp_q.pop_front();
          w  = mem_word(e);
          en = e + 16'd2;
          check("instr_pc", 32'(instr_pc), 32'(e));
          check("instr", 32'(instr), 32'(w));
          check("instr_pc_next", 32'(instr_pc_next), 32'(en));
          if (chk_spacing && last_acc >= 0) check("accept_spacing", 32'(cyc - last_acc), 32'd3);
          last_acc = cyc;
          if (w[15:12] == 4'hF) begin
            model_halted = 1'b1;
            halt_pc      = e;
          end else begin
            exp_q.push_back(en);
          end
        end
      end
      if (redirect_valid && !model_halted) begin
        exp_q.delete();
        exp_q.push_back(redirect_pc);
      end
      if (!model_halted) begin
        idle++;
        if (idle > 300) begin
          check("watchdog_idle_cycles", 32'(idle), 32'd300);
          idle = 0;
        end
      end
    end
  end

  task automatic wait_valid(input int limit);
    int k = 0;
    while (!instr_valid && k < limit) begin
      tick(1);
      k++;
    end
    check("wait_instr_valid", 32'(instr_valid), 32'd1);
  endtask

  // Called at posedge+1; asserts rst between edges, releases it between edges.
  task automatic do_reset(input logic [15:0] h);
    #2 rst = 1'b1;
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_hlt", 32'(hlt), 32'd0);
    check("rst_pc", 32'(pc), 32'h0000);
    check("rst_instr_fields", 32'({instr, instr_pc}) | 32'(instr_pc_next), 32'd0);
    hlt_addr       = h;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    tick(1);
    check("req_after_rst", 32'({imem_req, imem_addr}), 32'({1'b1, 16'h0000}));
  endtask

  initial begin
    logic [15:0] old_addr;
    int k;
    rst            = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    mem_lat        = 1;
    hlt_addr       = 16'h0001;
    chk_spacing    = 1'b0;
    tick(1);

    // Streaming with 1-cycle memory and decode always ready.
    do_reset(16'h0001);
    instr_ready = 1'b1;
    chk_spacing = 1'b1;
    tick(14);
    chk_spacing = 1'b0;

    // Wrap-around after redirect to the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    tick(1);
    redirect_valid = 1'b0;
    tick(10);

    // Decode stall in HOLD, then release.
    instr_ready = 1'b0;
    wait_valid(20);
    tick(5);
    check("stall_valid_req", 32'({instr_valid, imem_req}), 32'b10);
    instr_ready = 1'b1;
    tick(1);
    check("release_new_req", 32'({instr_valid, imem_req}), 32'b01);

    // Redirect one cycle into a 4-cycle request: old response must be dropped.
    mem_lat     = 4;
    instr_ready = 1'b0;
    wait_valid(20);
    instr_ready = 1'b1;
    tick(1);
    old_addr = imem_addr;
    tick(1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    tick(1);
    redirect_valid = 1'b0;
    check("squash_addr_hold", 32'({imem_req, imem_addr}), 32'({1'b1, old_addr}));
    check("squash_pc", 32'(pc), 32'h0040);
    tick(20);

    // Reset pulsed while a request is outstanding, then HLT at 0x000A.
    k = 0;
    while (!mem_busy && k < 20) begin
      tick(1);
      k++;
    end
    mem_lat = 1;
    do_reset(16'h000A);
    instr_ready = 1'b1;
    tick(25);
    check("hlt_set", 32'({hlt, pc}), 32'({1'b1, 16'h000A}));
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0080;
    tick(1);
    redirect_valid = 1'b0;
    tick(10);
    check("hlt_sticky", 32'({hlt, imem_req, pc}), 32'({2'b10, 16'h000A}));

    // HLT sitting in HOLD, killed by a redirect in the same cycle decode accepts it.
    do_reset(16'h000A);
    k = 0;
    while (k < 20) begin
      wait_valid(20);
      if (instr_pc == 16'h000A) break;
      instr_ready = 1'b1;
      tick(1);
      instr_ready = 1'b0;
      k++;
    end
    check("hold_hlt_instr", 32'({instr_pc, instr}), 32'({16'h000A, 16'hF000}));
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    instr_ready    = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
    tick(12);
    check("hlt_not_set", 32'(hlt), 32'd0);

    // Random traffic, no reachable HLT.
    do_reset(16'h0001);
    for (int i = 0; i < 3000; i++) begin
      instr_ready    = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 16) == 0;
      redirect_pc    = 16'($urandom) & 16'hFFFE;
      mem_lat        = 1 + int'($urandom % 4);
      tick(1);
    end

    // Random traffic confined to a small region containing an HLT.
    do_reset(16'h0010);
    for (int i = 0; i < 600; i++) begin
      instr_ready    = ($urandom % 3) != 0;
      redirect_valid = ($urandom % 12) == 0;
      redirect_pc    = 16'($urandom_range(0, 15) * 2);
      mem_lat        = 1 + int'($urandom % 4);
      tick(1);
    end
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    tick(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
